gsim_residual: RTL

Downstream checker for the GSIM solver. It captures the 16 right-hand-side values `b` from the solver's input stream and the 16 solution words `x` from the solver's output stream. It then computes each residual r_i = (M·x)_i − b_i, where M is the banded matrix with taps −1, 6, −13, 20, −13, 6, −1. It streams the 16 residuals, then reports the peak |r| and a pass flag against a tolerance, giving an on-chip convergence check for the solver.

---
 rtl/gsim_pkg.sv | 12 +
 rtl/gsim_band_mac.sv | 18 +
 rtl/gsim_residual.sv | 102 ++++++++++
 3 files changed

// File: rtl/gsim_pkg.sv
// gsim_pkg: shared widths, band taps, FSM states and sign-extension helper for the GSIM residual checker
package gsim_pkg;
    localparam int B_W  = 16;
    localparam int X_W  = 32;
    localparam int R_W  = 40;
    localparam int FRAC = 16;
    localparam int TAPS [7] = '{-1, 6, -13, 20, -13, 6, -1};
    typedef enum logic [1:0] {ST_COLLECT, ST_CALC, ST_DONE} state_t;
    function automatic logic signed [R_W-1:0] ext_x(input logic [X_W-1:0] x);
        return {{(R_W-X_W){x[X_W-1]}}, x};
    endfunction
endpackage

// File: rtl/gsim_band_mac.sv
// gsim_band_mac: combinational 7-tap shift-add band product minus b (i_x_win: 7 Q16.16 taps, lowest first; i_b: integer b; o_r: Q24.16 residual)
module gsim_band_mac
    import gsim_pkg::*;
(
    input  logic [7*X_W-1:0] i_x_win,
    input  logic [B_W-1:0]   i_b,
    output logic [R_W-1:0]   o_r
);
    logic signed [R_W-1:0] w_o, w_s, w_m, w_c, w_b;
    // the band is symmetric, so mirrored taps are paired before scaling
    assign w_o = ext_x(i_x_win[0*X_W +: X_W]) + ext_x(i_x_win[6*X_W +: X_W]);
    assign w_s = ext_x(i_x_win[1*X_W +: X_W]) + ext_x(i_x_win[5*X_W +: X_W]);
    assign w_m = ext_x(i_x_win[2*X_W +: X_W]) + ext_x(i_x_win[4*X_W +: X_W]);
    assign w_c = ext_x(i_x_win[3*X_W +: X_W]);
    assign w_b = {{(R_W-B_W-FRAC){i_b[B_W-1]}}, i_b, {FRAC{1'b0}}};
    assign o_r = (w_c <<< 4) + (w_c <<< 2) + (w_s <<< 2) + (w_s <<< 1)
               - (w_m <<< 3) - (w_m <<< 2) - w_m - w_o - w_b;
endmodule

// File: rtl/gsim_residual.sv
// gsim_residual: captures b and x frames, streams band residuals, reports peak |r| and pass (in: clk, reset, in_en/b_in, out_valid/x_out; out: res_valid/res_idx/res_out, done, peak_abs, pass)
module gsim_residual
    import gsim_pkg::*;
#(
    parameter int              N   = 16,
    parameter logic [R_W-1:0]  TOL = 40'd16,
    localparam int             IW  = $clog2(N),
    localparam int             CW  = $clog2(N+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_en,
    input  logic [B_W-1:0]   b_in,
    input  logic             out_valid,
    input  logic [X_W-1:0]   x_out,
    output logic             res_valid,
    output logic [IW-1:0]    res_idx,
    output logic [R_W-1:0]   res_out,
    output logic             done,
    output logic [R_W-1:0]   peak_abs,
    output logic             pass
);
    state_t            r_state, w_next;
    logic [CW-1:0]     r_b_cnt, r_x_cnt, w_b_cnt_nxt, w_x_cnt_nxt;
    logic [IW-1:0]     r_i;
    logic [R_W-1:0]    r_peak, w_r, w_abs;
    logic [B_W-1:0]    r_b [N];
    logic [X_W-1:0]    r_x [N];
    logic [X_W-1:0]    w_xp [N+6];
    logic [7*X_W-1:0]  w_win;
    logic              w_b_take, w_x_take, w_start;

    assign w_b_take    = in_en && r_state == ST_COLLECT && r_b_cnt != CW'(N);
    assign w_x_take    = out_valid && r_state == ST_COLLECT && r_x_cnt != CW'(N);
    assign w_b_cnt_nxt = r_b_cnt + CW'(w_b_take);
    assign w_x_cnt_nxt = r_x_cnt + CW'(w_x_take);
    assign w_start     = r_state == ST_COLLECT && w_b_cnt_nxt == CW'(N) && w_x_cnt_nxt == CW'(N);

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= ST_COLLECT;
        else       r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_COLLECT: w_next = w_start ? ST_CALC : ST_COLLECT;
            ST_CALC:    w_next = r_i == IW'(N-1) ? ST_DONE : ST_CALC;
            default:    w_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_b_take) r_b[r_b_cnt[IW-1:0]] <= b_in;
        if (w_x_take) r_x[r_x_cnt[IW-1:0]] <= x_out;
    end

    // x padded with three zeros on each side so the window never needs range checks
    always_comb begin
        for (int p = 0; p < N+6; p++) w_xp[p] = '0;
        for (int p = 0; p < N; p++) w_xp[p+3] = r_x[p];
        w_win = '0;
        for (int k = 0; k < 7; k++) w_win[k*X_W +: X_W] = w_xp[{1'b0, r_i} + (IW+1)'(k)];
    end

    gsim_band_mac u_mac (
        .i_x_win (w_win),
        .i_b     (r_b[r_i]),
        .o_r     (w_r)
    );

    assign w_abs = w_r[R_W-1] ? -w_r : w_r;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_b_cnt   <= '0;
            r_x_cnt   <= '0;
            r_i       <= '0;
            r_peak    <= '0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_out   <= '0;
            done      <= 1'b0;
            peak_abs  <= '0;
            pass      <= 1'b0;
        end else begin
            r_b_cnt   <= r_state == ST_DONE ? '0 : w_b_cnt_nxt;
            r_x_cnt   <= r_state == ST_DONE ? '0 : w_x_cnt_nxt;
            r_i       <= r_state == ST_CALC ? r_i + 1'b1 : '0;
            res_valid <= r_state == ST_CALC;
            done      <= r_state == ST_DONE;
            if (r_state == ST_CALC) begin
                res_out <= w_r;
                res_idx <= r_i;
                r_peak  <= w_abs > r_peak ? w_abs : r_peak;
            end
            if (r_state == ST_DONE) begin
                r_peak   <= '0;
                peak_abs <= r_peak;
                pass     <= r_peak <= TOL;
            end
        end
endmodule
